spi_slave: RTL and testbench

SPI responder for the other end of the team's SPI master link. It over-samples the asynchronous sclk/cs_n/mosi pins on the system clock, supports all four CPOL/CPHA modes, and moves 8-bit frames MSB-first. A one-byte TX holding buffer with a valid/ready handshake supplies the bytes sent on miso. Each received byte is presented as rx_data with a one-cycle rx_valid pulse.

---
 rtl/spi_slave.sv | 221 ++++++++++++++++++++++
 tb/tb_spi_slave.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// spi_slave: SPI responder that over-samples sclk/cs_n/mosi on clk.
// Supports all four CPOL/CPHA modes and moves 8-bit frames MSB first.
// A one-byte TX holding buffer with a valid/ready handshake feeds miso.
// Each received byte is presented on rx_data with a one-cycle rx_valid pulse.
// Build option: define SPI_SLAVE_OVERRUN_DET_EN to build the sticky TX
// underrun/overflow flag; otherwise overrun is tied low.
module spi_slave #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  DEFAULT_TX  = 8'hFF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       cpol,
    input  logic       cpha,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       overrun
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_prev;
    logic                   cs_prev;

    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic lead_edge, trail_edge, sample_edge, shift_edge;
    logic frame_start, frame_stop, in_frame;
    logic do_sample, do_shift, load;

    logic [2:0] bit_cnt;
    logic [7:0] rx_shift;
    logic [7:0] rx_next;
    logic [7:0] tx_shift;
    logic       miso_reg;
    logic [7:0] buf_data;
    logic       buf_full;
    logic [7:0] load_byte;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // Input synchronisers plus previous-value flops for edge detection.
    // cs_n resets low so a select already held low at reset release is
    // not mistaken for a fresh falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_prev <= sclk_s;
            cs_prev   <= cs_s;
        end
    end

    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign cs_fall   = ~cs_s & cs_prev;
    assign cs_rise   = cs_s & ~cs_prev;

    // Leading edge leaves the idle level, trailing edge returns to it.
    assign lead_edge   = cpol ? sclk_fall : sclk_rise;
    assign trail_edge  = cpol ? sclk_rise : sclk_fall;
    assign sample_edge = cpha ? trail_edge : lead_edge;
    assign shift_edge  = cpha ? lead_edge : trail_edge;

    // Frame state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic with frame start/stop strobes.
    always_comb begin
        state_next  = state_reg;
        frame_start = 1'b0;
        frame_stop  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (cs_fall && enable) begin
                    state_next  = ACTIVE;
                    frame_start = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_rise || !enable) begin
                    state_next = IDLE;
                    frame_stop = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // SCLK edges only count while a frame is open and not closing this cycle.
    assign in_frame  = (state_reg == ACTIVE) && !frame_stop;
    assign do_sample = in_frame && sample_edge;
    assign do_shift  = in_frame && shift_edge;

    // With cpha=0 the first edge is a sample, so a shift edge at bit count 0
    // only follows a completed byte; with cpha=1 it is the first edge of a byte.
    assign load      = (frame_start && !cpha) || (do_shift && (bit_cnt == 3'd0));
    assign load_byte = buf_full ? buf_data : DEFAULT_TX;
    assign rx_next   = {rx_shift[6:0], mosi_s};

    // Bit counter: cleared at frame boundaries, wraps 7->0 between bytes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= 3'd0;
        end else if (frame_start || frame_stop) begin
            bit_cnt <= 3'd0;
        end else if (do_sample) begin
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

    // RX shift register and byte delivery; partial bytes never reach rx_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_shift <= 8'h00;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (do_sample) begin
                rx_shift <= rx_next;
                if (bit_cnt == 3'd7) begin
                    rx_data  <= rx_next;
                    rx_valid <= 1'b1;
                end
            end
        end
    end

    // TX shift register: load points present the MSB at once, other shift
    // edges advance to the next bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shift <= 8'h00;
            miso_reg <= 1'b0;
        end else if (load) begin
            miso_reg <= load_byte[7];
            tx_shift <= {load_byte[6:0], 1'b0};
        end else if (do_shift) begin
            miso_reg <= tx_shift[7];
            tx_shift <= {tx_shift[6:0], 1'b0};
        end
    end

    // Holding buffer: a load empties it first, so a same-cycle write is kept
    // for the following load point.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_data <= 8'h00;
            buf_full <= 1'b0;
        end else begin
            if (load) begin
                buf_full <= 1'b0;
            end
            if (tx_valid && !buf_full) begin
                buf_data <= tx_data;
                buf_full <= 1'b1;
            end
        end
    end

    assign tx_ready = ~buf_full;
    assign miso     = miso_reg;
    assign busy     = (state_reg == ACTIVE) && enable;
    assign miso_oe  = (state_reg == ACTIVE) && enable;

`ifdef SPI_SLAVE_OVERRUN_DET_EN
    logic overrun_reg;

    // Sticky fault flag: a fresh select clears it, but a fault raised in the
    // same cycle (empty buffer at the cs_n-fall load) takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_reg <= 1'b0;
        end else if ((load && !buf_full) || (tx_valid && buf_full)) begin
            overrun_reg <= 1'b1;
        end else if (cs_fall) begin
            overrun_reg <= 1'b0;
        end
    end

    assign overrun = overrun_reg;
`else
    assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: drives spi_slave as an SPI master and checks it against a
// transaction-level model (byte queues plus a one-entry buffer model).
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       cpol;
    logic       cpha;
    logic       sclk;
    logic       cs_n;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       overrun;

    always #5 clk = ~clk;

    spi_slave #(
        .SYNC_STAGES(2),
        .DEFAULT_TX (8'hFF)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (enable),
        .cpol    (cpol),
        .cpha    (cpha),
        .sclk    (sclk),
        .cs_n    (cs_n),
        .mosi    (mosi),
        .miso    (miso),
        .miso_oe (miso_oe),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .busy    (busy),
        .overrun (overrun)
    );

    int         tests = 0;
    int         fails = 0;
    int         rx_pulses = 0;
    logic [7:0] exp_rx[$];
    logic [7:0] last_rx = 8'h00;
    logic       model_full = 1'b0;
    logic [7:0] model_buf = 8'h00;
    logic       model_ovr = 1'b0;
    logic [7:0] mosi_bytes[4];
    logic [7:0] got_miso[4];
    bit         dead = 1'b0;

    task automatic chk8(input string name, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %02h, required %02h", name, got, exp);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %b, required %b", name, got, exp);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    function automatic logic exp_ovr();
`ifdef SPI_SLAVE_OVERRUN_DET_EN
        return model_ovr;
`else
        return 1'b0;
`endif
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Model: a load point takes the buffered byte, or the default when empty.
    task automatic model_load(output logic [7:0] b);
        if (model_full) begin
            b          = model_buf;
            model_full = 1'b0;
        end else begin
            b         = 8'hFF;
            model_ovr = 1'b1;
        end
    endtask

    // One-cycle tx_valid strobe; accepted only if the model buffer is empty.
    task automatic push_tx(input logic [7:0] v);
        tx_data  = v;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        if (model_full) begin
            model_ovr = 1'b1;
        end else begin
            model_full = 1'b1;
            model_buf  = v;
        end
    endtask

    task automatic set_mode(input logic cp, input logic ch);
        cpol = cp;
        cpha = ch;
        sclk = cp;
        wait_cycles(6);
    endtask

    task automatic check_reset_values();
        chk1("rst_miso", miso, 1'b0);
        chk1("rst_miso_oe", miso_oe, 1'b0);
        chk1("rst_tx_ready", tx_ready, 1'b1);
        chk8("rst_rx_data", rx_data, 8'h00);
        chk1("rst_rx_valid", rx_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_overrun", overrun, 1'b0);
    endtask

    task automatic mid_reset();
        rst_n = 1'b0;
        dead  = 1'b1;
        wait_cycles(2);
        check_reset_values();
        model_full = 1'b0;
        model_ovr  = 1'b0;
        last_rx    = 8'h00;
        exp_rx.delete();
        rst_n = 1'b1;
    endtask

    task automatic byte_done(input int b, input logic [7:0] rcv, input logic [7:0] exp_tx);
        got_miso[b] = rcv;
        if (!dead) begin
            chk8("miso_byte", rcv, exp_tx);
            exp_rx.push_back(mosi_bytes[b]);
        end
    endtask

    task automatic quiet_checks();
        chk1("idle_busy", busy, 1'b0);
        chk1("idle_miso_oe", miso_oe, 1'b0);
        chk1("idle_tx_ready", tx_ready, !model_full);
        chk1("idle_overrun", overrun, exp_ovr());
        chk_int("rx_pending", exp_rx.size(), 0);
    endtask

    // One master frame. cut_bits>0 raises cs_n after that many bits;
    // refill_byte>=0 pushes refill_val after bit 3 of that byte.
    task automatic frame(input int nbytes, input int cut_bits, input bit rst_mid,
                         input int refill_byte, input logic [7:0] refill_val);
        int         h;
        int         total;
        logic [7:0] exp_tx;
        logic [7:0] rcv;
        h      = int'($urandom_range(4, 8));
        total  = (cut_bits > 0) ? cut_bits : nbytes * 8;
        dead   = !enable;
        exp_tx = 8'h00;
        rcv    = 8'h00;
        cs_n   = 1'b0;
        model_ovr = 1'b0;
        if (!dead && !cpha) model_load(exp_tx);
        wait_cycles(h);
        chk1("frame_busy", busy, !dead);
        chk1("frame_miso_oe", miso_oe, !dead);
        chk1("frame_overrun", overrun, exp_ovr());
        for (int k = 0; k < total; k++) begin
            int b;
            int i;
            b = k / 8;
            i = 7 - (k % 8);
            if (i == 7) begin
                rcv = 8'h00;
                if (!dead && cpha) model_load(exp_tx);
            end
            if (!cpha) begin
                mosi = mosi_bytes[b][i];
                wait_cycles(h);
                rcv[i] = miso;
                sclk = ~cpol;
                if (i == 0) byte_done(b, rcv, exp_tx);
                wait_cycles(h);
                sclk = cpol;
                if (i == 0 && !dead) model_load(exp_tx);
            end else begin
                sclk = ~cpol;
                mosi = mosi_bytes[b][i];
                wait_cycles(h);
                rcv[i] = miso;
                sclk = cpol;
                if (i == 0) byte_done(b, rcv, exp_tx);
                wait_cycles(h);
            end
            if (!dead && b == refill_byte && i == 4) push_tx(refill_val);
            if (rst_mid && k == 2) mid_reset();
        end
        wait_cycles(h);
        cs_n = 1'b1;
        wait_cycles(h + 4);
        quiet_checks();
    endtask

    // Compare process: every rx_valid must match the next expected byte,
    // and rx_data must hold its last delivered value between pulses.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid) begin
                rx_pulses++;
                tests++;
                if (exp_rx.size() == 0) begin
                    fails++;
                    $display("FAIL rx_unexpected: got rx_valid with rx_data=%02h, required no pulse", rx_data);
                end else begin
                    last_rx = exp_rx.pop_front();
                    if (rx_data !== last_rx) begin
                        fails++;
                        $display("FAIL rx_byte: got %02h, required %02h", rx_data, last_rx);
                    end
                end
            end else begin
                tests++;
                if (rx_data !== last_rx) begin
                    fails++;
                    $display("FAIL rx_hold: got %02h, required %02h", rx_data, last_rx);
                end
            end
        end
    end

    initial begin
        int p;
        rst_n    = 1'b0;
        enable   = 1'b1;
        cpol     = 1'b0;
        cpha     = 1'b0;
        sclk     = 1'b0;
        cs_n     = 1'b1;
        mosi     = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        wait_cycles(3);
        check_reset_values();
        rst_n = 1'b1;
        wait_cycles(4);

        // Mode 0: A5 out, 3C in.
        set_mode(1'b0, 1'b0);
        push_tx(8'hA5);
        mosi_bytes[0] = 8'h3C;
        p = rx_pulses;
        frame(1, 0, 1'b0, -1, 8'h00);
        chk8("t1_miso", got_miso[0], 8'hA5);
        chk8("t1_rx_data", rx_data, 8'h3C);
        chk_int("t1_pulses", rx_pulses - p, 1);
        chk1("t1_tx_ready", tx_ready, 1'b1);

        // Mode 3: 81 out, C3 in.
        set_mode(1'b1, 1'b1);
        push_tx(8'h81);
        mosi_bytes[0] = 8'hC3;
        frame(1, 0, 1'b0, -1, 8'h00);
        chk8("t2_miso", got_miso[0], 8'h81);
        chk8("t2_rx_data", rx_data, 8'hC3);

        // Mode 1 two-byte frame with refill during byte 1.
        set_mode(1'b0, 1'b1);
        push_tx(8'h11);
        mosi_bytes[0] = 8'hF0;
        mosi_bytes[1] = 8'h0F;
        p = rx_pulses;
        frame(2, 0, 1'b0, 0, 8'h22);
        chk8("t3_miso0", got_miso[0], 8'h11);
        chk8("t3_miso1", got_miso[1], 8'h22);
        chk_int("t3_pulses", rx_pulses - p, 2);
        chk8("t3_rx_data", rx_data, 8'h0F);

        // Empty buffer: default byte goes out.
        set_mode(1'b0, 1'b0);
        mosi_bytes[0] = 8'h96;
        frame(1, 0, 1'b0, -1, 8'h00);
        chk8("t4_miso", got_miso[0], 8'hFF);
`ifdef SPI_SLAVE_OVERRUN_DET_EN
        chk1("t4_overrun", overrun, 1'b1);
`endif

        // Abort after 5 bits, then a full frame.
        push_tx(8'h77);
        mosi_bytes[0] = 8'hE7;
        p = rx_pulses;
        frame(1, 5, 1'b0, -1, 8'h00);
        chk_int("t5_abort_pulses", rx_pulses - p, 0);
        chk8("t5_rx_kept", rx_data, 8'h96);
        mosi_bytes[0] = 8'h5A;
        frame(1, 0, 1'b0, -1, 8'h00);
        chk8("t5_rx_data", rx_data, 8'h5A);

        // Reset after 3 bits; remaining edges must produce nothing.
        set_mode(1'b1, 1'b0);
        push_tx(8'h33);
        mosi_bytes[0] = 8'hC9;
        p = rx_pulses;
        frame(1, 0, 1'b1, -1, 8'h00);
        chk_int("t6_pulses", rx_pulses - p, 0);
        chk8("t6_rx_data", rx_data, 8'h00);
        chk1("t6_tx_ready", tx_ready, 1'b1);

        // Disabled block ignores a whole frame.
        enable = 1'b0;
        mosi_bytes[0] = 8'h42;
        p = rx_pulses;
        frame(1, 0, 1'b0, -1, 8'h00);
        chk_int("t7_pulses", rx_pulses - p, 0);
        enable = 1'b1;
        wait_cycles(4);

        // Randomized frames across all modes.
        for (int n = 0; n < 40; n++) begin
            logic cp;
            logic ch;
            int   nb;
            int   cut;
            int   rb;
            cp = 1'($urandom_range(0, 1));
            ch = 1'($urandom_range(0, 1));
            set_mode(cp, ch);
            nb = int'($urandom_range(1, 3));
            for (int j = 0; j < 4; j++) mosi_bytes[j] = 8'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                push_tx(8'($urandom));
                chk1("pre_tx_ready", tx_ready, !model_full);
                chk1("pre_overrun", overrun, exp_ovr());
            end
            cut = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, nb * 8 - 1)) : 0;
            rb  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, nb - 1)) : -1;
            frame(nb, cut, 1'b0, rb, 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
